// File: rtl/reg_route_pkg.sv
// -----------------------------------------------------------------------------
// reg_route_pkg
// Shared definitions for the register-routing unit.
//   mode_e  : operand-routing mode encodings (RR, RRR, RI, W)
//   route_t : routed read/write addresses plus their use flags
// Addresses in route_t are ROUTE_AW_MAX bits wide so one struct serves any
// instance with AW <= ROUTE_AW_MAX; users take the low AW bits.
// -----------------------------------------------------------------------------
package reg_route_pkg;

  typedef enum logic [1:0] {
    MODE_RR  = 2'd0,
    MODE_RRR = 2'd1,
    MODE_RI  = 2'd2,
    MODE_W   = 2'd3
  } mode_e;

  localparam int unsigned ROUTE_AW_MAX = 8;

  typedef logic [ROUTE_AW_MAX-1:0] route_addr_t;

  typedef struct packed {
    route_addr_t r1;
    route_addr_t r2;
    route_addr_t rw;
    logic        r1_en;
    logic        r2_en;
    logic        rw_en;
  } route_t;

endpackage

// File: rtl/reg_route_unit_decode.sv
// -----------------------------------------------------------------------------
// reg_route_decode
// Combinational mode mux: picks which instruction fields feed R1/R2/RW.
// Unused addresses are forced to zero, never left as don't-care.
// Ports:
//   mode                 : routing mode (mode_e encoding)
//   rAlpha/rBeta/rGamma  : instruction register fields, AW bits each
//   route                : routed addresses + enables (zero-extended)
// -----------------------------------------------------------------------------
module reg_route_decode
  import reg_route_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic [1:0]    mode,
  input  logic [AW-1:0] rAlpha,
  input  logic [AW-1:0] rBeta,
  input  logic [AW-1:0] rGamma,
  output route_t        route
);

  always_comb begin
    route = '0;
    case (mode_e'(mode))
      MODE_RR: begin
        route.r1    = route_addr_t'(rAlpha);
        route.r2    = route_addr_t'(rBeta);
        route.r1_en = 1'b1;
        route.r2_en = 1'b1;
      end
      MODE_RRR: begin
        route.r1    = route_addr_t'(rBeta);
        route.r2    = route_addr_t'(rGamma);
        route.rw    = route_addr_t'(rAlpha);
        route.r1_en = 1'b1;
        route.r2_en = 1'b1;
        route.rw_en = 1'b1;
      end
      MODE_RI: begin
        route.r1    = route_addr_t'(rBeta);
        route.rw    = route_addr_t'(rAlpha);
        route.r1_en = 1'b1;
        route.rw_en = 1'b1;
      end
      MODE_W: begin
        route.rw    = route_addr_t'(rAlpha);
        route.rw_en = 1'b1;
      end
      default: route = '0;
    endcase
  end

endmodule

// File: rtl/reg_route_unit.sv
// -----------------------------------------------------------------------------
// reg_route_unit
// Routes decoded instruction register fields onto read/write address ports,
// registers them behind a valid/ready output stage and tracks pending writes
// in a scoreboard that stalls RAW/WAW hazards.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and its payload until that edge; ready may
// depend on valid, but valid never depends on ready.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : input handshake for mode + rAlpha/rBeta/rGamma
//   mode                  : routing mode (see reg_route_pkg::mode_e)
//   out_valid / out_ready : output handshake for R1/R2/RW + enables
//   wb_valid, wb_reg      : writeback completion, clears busy[wb_reg]
//   busy                  : pending-write bit per register
// -----------------------------------------------------------------------------
module reg_route_unit
  import reg_route_pkg::*;
#(
  parameter int AW    = 2,
  parameter int SB_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [AW-1:0]     rAlpha,
  input  logic [AW-1:0]     rBeta,
  input  logic [AW-1:0]     rGamma,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     R1,
  output logic [AW-1:0]     R2,
  output logic [AW-1:0]     RW,
  output logic              r1_en,
  output logic              r2_en,
  output logic              rw_en,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_reg,
  output logic [(1<<AW)-1:0] busy
);

  localparam int NREGS = 1 << AW;

  route_t            w_route;
  logic [AW-1:0]     w_r1;
  logic [AW-1:0]     w_r2;
  logic [AW-1:0]     w_rw;
  logic [NREGS-1:0]  w_clr_mask;
  logic [NREGS-1:0]  w_set_mask;
  logic [NREGS-1:0]  w_busy_eff;
  logic              w_hazard;
  logic              w_accept;

  logic              r_out_valid;
  logic [AW-1:0]     r_r1;
  logic [AW-1:0]     r_r2;
  logic [AW-1:0]     r_rw;
  logic              r_r1_en;
  logic              r_r2_en;
  logic              r_rw_en;
  logic [NREGS-1:0]  r_busy;

  reg_route_decode #(.AW(AW)) u_decode (
    .mode   (mode),
    .rAlpha (rAlpha),
    .rBeta  (rBeta),
    .rGamma (rGamma),
    .route  (w_route)
  );

  assign w_r1 = w_route.r1[AW-1:0];
  assign w_r2 = w_route.r2[AW-1:0];
  assign w_rw = w_route.rw[AW-1:0];

  // Upper address bits are always zero (zero-extended fields); fold them so
  // they are visibly consumed.
  if (AW < ROUTE_AW_MAX) begin : g_hi_bits
    logic w_unused_hi;
    assign w_unused_hi = ^{w_route.r1[ROUTE_AW_MAX-1:AW],
                           w_route.r2[ROUTE_AW_MAX-1:AW],
                           w_route.rw[ROUTE_AW_MAX-1:AW]};
  end

  always_comb begin
    w_clr_mask = '0;
    if (wb_valid) w_clr_mask[wb_reg] = 1'b1;
  end

  always_comb begin
    w_set_mask = '0;
    if (w_accept && w_route.rw_en) w_set_mask[w_rw] = 1'b1;
  end

  // Same-cycle writeback is treated as already complete (bypass), so a
  // dependent instruction issues on the writeback cycle without a bubble.
  assign w_busy_eff = r_busy & ~w_clr_mask;

  always_comb begin
    w_hazard = 1'b0;
    if (SB_EN != 0 && in_valid) begin
      w_hazard = (w_route.r1_en && w_busy_eff[w_r1]) ||
                 (w_route.r2_en && w_busy_eff[w_r2]) ||
                 (w_route.rw_en && w_busy_eff[w_rw]);
    end
  end

  assign in_ready = rst_n & (~r_out_valid | out_ready) & ~w_hazard;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_r1        <= '0;
      r_r2        <= '0;
      r_rw        <= '0;
      r_r1_en     <= 1'b0;
      r_r2_en     <= 1'b0;
      r_rw_en     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_r1        <= w_r1;
      r_r2        <= w_r2;
      r_rw        <= w_rw;
      r_r1_en     <= w_route.r1_en;
      r_r2_en     <= w_route.r2_en;
      r_rw_en     <= w_route.rw_en;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Set wins over clear on the same register: the new writer is still pending.
  always_ff @(posedge clk) begin
    if (!rst_n || SB_EN == 0) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  assign out_valid = r_out_valid;
  assign R1        = r_r1;
  assign R2        = r_r2;
  assign RW        = r_rw;
  assign r1_en     = r_r1_en;
  assign r2_en     = r_r2_en;
  assign rw_en     = r_rw_en;
  assign busy      = r_busy;

endmodule

// File: tb/tb_reg_route_unit.sv
// -----------------------------------------------------------------------------
// tb_reg_route_unit
// Directed bench for reg_route_unit with AW=2, SB_EN=1. Inputs change on the
// falling edge; registered outputs are sampled 1 time unit after the rising
// edge, combinational in_ready 1 time unit after the inputs change.
// Output bundle obs = {out_valid, R1, R2, RW, r1_en, r2_en, rw_en}.
// -----------------------------------------------------------------------------
module tb_reg_route_unit;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [AW-1:0] rAlpha;
  logic [AW-1:0] rBeta;
  logic [AW-1:0] rGamma;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] R1;
  logic [AW-1:0] R2;
  logic [AW-1:0] RW;
  logic          r1_en;
  logic          r2_en;
  logic          rw_en;
  logic          wb_valid;
  logic [AW-1:0] wb_reg;
  logic [3:0]    busy;

  logic [9:0]    obs;
  int            errors;
  int            checks;

  assign obs = {out_valid, R1, R2, RW, r1_en, r2_en, rw_en};

  reg_route_unit #(.AW(AW), .SB_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .rAlpha    (rAlpha),
    .rBeta     (rBeta),
    .rGamma    (rGamma),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R1        (R1),
    .R2        (R2),
    .RW        (RW),
    .r1_en     (r1_en),
    .r2_en     (r2_en),
    .rw_en     (rw_en),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] m,
                       input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] g);
    in_valid = v;
    mode     = m;
    rAlpha   = a;
    rBeta    = b;
    rGamma   = g;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    wb_valid  = 1'b0;
    wb_reg    = 2'd0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd1, 2'd1, 2'd2, 2'd3);
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_reg    = 2'd0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 10'd0) begin
      $display("FAIL reset_outputs: got %b expected %b", obs, 10'd0);
      errors++;
    end
    checks++;
    if (busy !== 4'b0000) begin
      $display("FAIL reset_busy: got %b expected 0000", busy);
      errors++;
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
      errors++;
    end
  endtask

  task automatic test_rrr();
    @(negedge clk);
    drive(1'b1, 2'd1, 2'd1, 2'd2, 2'd3);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rrr_in_ready: got %b expected 1", in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== {1'b1, 2'd2, 2'd3, 2'd1, 3'b111}) begin
      $display("FAIL rrr_outputs: got %b expected %b", obs, {1'b1, 2'd2, 2'd3, 2'd1, 3'b111});
      errors++;
    end
    checks++;
    if (busy !== 4'b0010) begin
      $display("FAIL rrr_busy: got %b expected 0010", busy);
      errors++;
    end
    idle_cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rrr_drain: got %b expected 0", out_valid);
      errors++;
    end
  endtask

  task automatic test_rr();
    @(negedge clk);
    drive(1'b1, 2'd0, 2'd3, 2'd0, 2'd2);
    @(posedge clk);
    #1;
    checks++;
    if (obs !== {1'b1, 2'd3, 2'd0, 2'd0, 3'b110}) begin
      $display("FAIL rr_outputs: got %b expected %b", obs, {1'b1, 2'd3, 2'd0, 2'd0, 3'b110});
      errors++;
    end
    checks++;
    if (busy !== 4'b0010) begin
      $display("FAIL rr_busy: got %b expected 0010", busy);
      errors++;
    end
    idle_cycle();
  endtask

  // busy[1] is pending; an RI reading reg 1 must wait for its writeback.
  task automatic test_hazard();
    @(negedge clk);
    drive(1'b1, 2'd2, 2'd0, 2'd1, 2'd3);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL hazard_stall_%0d: got %b expected 0", i, in_ready);
        errors++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL hazard_no_issue_%0d: got %b expected 0", i, out_valid);
        errors++;
      end
      @(negedge clk);
    end
    wb_valid = 1'b1;
    wb_reg   = 2'd1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL hazard_bypass_ready: got %b expected 1", in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== {1'b1, 2'd1, 2'd0, 2'd0, 3'b101}) begin
      $display("FAIL hazard_outputs: got %b expected %b", obs, {1'b1, 2'd1, 2'd0, 2'd0, 3'b101});
      errors++;
    end
    checks++;
    if (busy !== 4'b0001) begin
      $display("FAIL hazard_busy: got %b expected 0001", busy);
      errors++;
    end
    idle_cycle();
  endtask

  task automatic test_set_clear();
    @(negedge clk);
    drive(1'b1, 2'd3, 2'd2, 2'd1, 2'd1);
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 4'b0101) begin
      $display("FAIL setclr_first_busy: got %b expected 0101", busy);
      errors++;
    end
    @(negedge clk);
    wb_valid = 1'b1;
    wb_reg   = 2'd2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL setclr_ready: got %b expected 1", in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 4'b0101) begin
      $display("FAIL setclr_busy: got %b expected 0101", busy);
      errors++;
    end
    checks++;
    if (obs !== {1'b1, 2'd0, 2'd0, 2'd2, 3'b001}) begin
      $display("FAIL setclr_outputs: got %b expected %b", obs, {1'b1, 2'd0, 2'd0, 2'd2, 3'b001});
      errors++;
    end
    idle_cycle();
  endtask

  // Writeback to an idle register is a no-op; then drain the scoreboard.
  task automatic test_wb_idle();
    @(negedge clk);
    wb_valid = 1'b1;
    wb_reg   = 2'd3;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 4'b0101) begin
      $display("FAIL wb_idle_busy: got %b expected 0101", busy);
      errors++;
    end
    @(negedge clk);
    wb_reg = 2'd0;
    @(negedge clk);
    wb_reg = 2'd2;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 4'b0000) begin
      $display("FAIL wb_drain_busy: got %b expected 0000", busy);
      errors++;
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(1'b1, 2'd0, 2'd1, 2'd2, 2'd0);
    out_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 2'd0, 2'd3, 2'd1, 2'd0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready);
        errors++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {1'b1, 2'd1, 2'd2, 2'd0, 3'b110}) begin
        $display("FAIL bp_hold_%0d: got %b expected %b", i, obs, {1'b1, 2'd1, 2'd2, 2'd0, 3'b110});
        errors++;
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== {1'b1, 2'd3, 2'd1, 2'd0, 3'b110}) begin
      $display("FAIL bp_next_item: got %b expected %b", obs, {1'b1, 2'd3, 2'd1, 2'd0, 3'b110});
      errors++;
    end
    idle_cycle();
  endtask

  // Consecutive RR items must issue one per cycle.
  task automatic test_back_to_back();
    logic [1:0] a_tab [3];
    logic [1:0] b_tab [3];
    a_tab = '{2'd0, 2'd2, 2'd1};
    b_tab = '{2'd3, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 2'd0, a_tab[i], b_tab[i], 2'd0);
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {1'b1, a_tab[i], b_tab[i], 2'd0, 3'b110}) begin
        $display("FAIL b2b_item_%0d: got %b expected %b", i, obs, {1'b1, a_tab[i], b_tab[i], 2'd0, 3'b110});
        errors++;
      end
    end
    idle_cycle();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    drive(1'b1, 2'd3, 2'd1, 2'd0, 2'd0);
    @(negedge clk);
    drive(1'b1, 2'd3, 2'd3, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 4'b1010) begin
      $display("FAIL midrst_setup_busy: got %b expected 1010", busy);
      errors++;
    end
    @(negedge clk);
    drive(1'b1, 2'd1, 2'd0, 2'd2, 2'd2);
    wb_valid = 1'b1;
    wb_reg   = 2'd1;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL midrst_in_ready: got %b expected 0", in_ready);
      errors++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 4'b0000) begin
      $display("FAIL midrst_busy: got %b expected 0000", busy);
      errors++;
    end
    checks++;
    if (obs !== 10'd0) begin
      $display("FAIL midrst_outputs: got %b expected %b", obs, 10'd0);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_rrr();
    test_rr();
    test_hazard();
    test_set_clear();
    test_wb_idle();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
